// File: rtl/lab3_pkg.sv
// Shared definitions for the lab3 pattern checker: FSM state encoding,
// default seed pattern and the width of the mismatch counter.
package lab3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  localparam logic [7:0] DEFAULT_SEED = 8'b01010101;

  localparam int ERR_CNT_W = 5;

endpackage

// File: rtl/lab3_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment.
// Asserting clr_i and inc_i together loads 1, so "restart from one"
// needs no extra port. nxt_o exposes the value the next edge will
// load, which lets the owner make same-edge decisions on it.
module lab3_sat_cnt #(
  parameter int W   = 4,
  parameter int MAX = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Clear first, then increment unless already at the ceiling.
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base < MaxVal)) begin
      cnt_d = base + W'(1);
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/lab3_pattern_checker.sv
// Checks the alternating SEED / ~SEED stream from the toggling
// flip-flop bank: syncs onto it, then counts mismatches and latches
// a sticky failure once the error limit is reached.
module lab3_pattern_checker
  import lab3_pkg::*;
#(
  parameter int                 DFF_num   = 8,
  parameter logic [DFF_num-1:0] SEED      = DEFAULT_SEED,
  parameter int                 LOCK_LEN  = 4,
  parameter int                 ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DFF_num-1:0]   d,
  output logic                 locked,
  output logic                 fail,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [3:0]           LockVal = 4'(LOCK_LEN);
  localparam logic [ERR_CNT_W-1:0] ErrLim  = ERR_CNT_W'(ERR_LIMIT);

  state_e               state_q, state_d;
  logic [DFF_num-1:0]   exp_q, exp_d;
  logic                 pulse_q, pulse_d;

  logic                 run_clr, run_inc;
  logic [3:0]           run_q, run_nxt;
  logic                 err_clr, err_inc;
  logic [ERR_CNT_W-1:0] err_q, err_nxt;

  logic                 match;
  logic                 slip;
  logic                 drop;

  assign match = (d == exp_q);
  assign slip  = (d == ~exp_q);
  assign drop  = !en && (state_q != ST_FAIL);

  // Consecutive-correct-sample counter used while syncing.
  lab3_sat_cnt #(.W(4), .MAX(LOCK_LEN)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (run_clr),
    .inc_i (run_inc),
    .cnt_o (run_q),
    .nxt_o (run_nxt)
  );

  // Mismatch counter, saturating at its full width.
  lab3_sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (err_clr),
    .inc_i (err_inc),
    .cnt_o (err_q),
    .nxt_o (err_nxt)
  );

  // Datapath control: expected pattern, counter commands and error strobe.
  always_comb begin
    exp_d   = exp_q;
    run_clr = 1'b0;
    run_inc = 1'b0;
    err_clr = 1'b0;
    err_inc = 1'b0;
    pulse_d = 1'b0;
    if (clr) begin
      exp_d   = SEED;
      run_clr = 1'b1;
      err_clr = 1'b1;
    end else if (drop) begin
      exp_d   = SEED;
      run_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          exp_d   = SEED;
          run_clr = 1'b1;
          err_clr = 1'b1;
        end
        ST_SYNC: begin
          if (match) begin
            run_inc = 1'b1;
            exp_d   = ~exp_q;
          end else if (slip) begin
            run_clr = 1'b1;
            run_inc = 1'b1;
          end else begin
            run_clr = 1'b1;
            exp_d   = SEED;
          end
        end
        ST_LOCKED: begin
          exp_d = ~exp_q;
          if (!match) begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decision; lock and fail look at the counters' next values.
  always_comb begin
    state_d = state_q;
    if (clr || drop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SYNC;
        ST_SYNC:   if (run_nxt == LockVal) state_d = ST_LOCKED;
        ST_LOCKED: if (err_inc && (err_nxt >= ErrLim)) state_d = ST_FAIL;
        default:   state_d = ST_FAIL;
      endcase
    end
  end

  // State, expected-pattern and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      exp_q   <= SEED;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign fail      = (state_q == ST_FAIL);
  assign err_pulse = pulse_q;
  assign err_cnt   = err_q;

  // The sync run count must never exceed the lock length.
  assert property (@(posedge clk) disable iff (!rst_n) run_q <= LockVal);

endmodule

// File: doc/lab3_pattern_checker.md
# lab3_pattern_checker

Downstream consumer of the `lab3_prelab2` toggling flip-flop bank. It samples the bank's `q` bus every cycle and locks onto the alternating SEED / ~SEED sequence. Once locked, it counts mismatches and declares failure at a programmable error limit. It is the hardware counterpart of the bench golden-model check and drives lab status LEDs.

## Interface
Parameters:
- `DFF_num`, default 8: width of the checked bus.
- `SEED`, default 8'b01010101: first pattern expected after sync start; the complement alternates with it.
- `LOCK_LEN`, default 4: consecutive correct samples needed to lock (range 1–15).
- `ERR_LIMIT`, default 3: error count at which FAIL is entered (range 1–31).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: checker enable.
- `clr` input 1: synchronous clear; returns to IDLE and clears `err_cnt` and `fail`.
- `d` input DFF_num: sampled bus, connected to the upstream `q`.
- `locked` output 1: high while in LOCKED.
- `fail` output 1: high while in FAIL.
- `err_pulse` output 1: one-cycle strobe for each mismatch detected in LOCKED.
- `err_cnt` output 5: saturating mismatch count.

## Operation
- Internal registers: `state` (IDLE / SYNC / LOCKED / FAIL), `exp` (DFF_num bits, expected next sample), `run` (4 bits).
- Priority on each edge: `clr`, then `!en` (any state except FAIL goes to IDLE), then the state action.
- **IDLE**
  - Holds `exp=SEED` and `run=0`.
  - On `en=1`: go to SYNC; `err_cnt<=0`.
  - `err_cnt` keeps its last value while in IDLE.
- **SYNC**
  - If `d==exp`: `run<=run+1`, `exp<=~exp`.
  - Else if `d==~exp` (phase slip): `run<=1`, `exp` unchanged.
  - Else: `run<=0`, `exp<=SEED`.
  - Go to LOCKED on the edge where the updated `run` equals LOCK_LEN.
- **LOCKED**
  - `exp<=~exp` every cycle; phase is kept regardless of errors.
  - On `d!=exp`: `err_pulse<=1`, and `err_cnt<=err_cnt+1` (saturates at 31).
  - If the incremented count reaches ERR_LIMIT, go to FAIL on the same edge.
- **FAIL**
  - Sticky. Ignores `d` and `en`.
  - Leaves only on `clr` (to IDLE) or `rst_n` low.
- `clr` together with a mismatch on the same edge: `clr` wins, no pulse, count 0.
- `run` saturates at LOCK_LEN and never wraps.

## Timing
- Reset (asynchronous, immediate): state IDLE, `exp=SEED`, `run=0`, `locked=0`, `fail=0`, `err_pulse=0`, `err_cnt=0`.
- All outputs are registered.
  - `locked` and `fail` decode the registered state.
  - `err_pulse` and `err_cnt` update on the edge that samples the bad `d` and are visible one cycle after that sample.
- Lock latency: LOCK_LEN sampled edges after the first correct sample in SYNC.
  - With aligned input from `en` rising, `locked` goes high after LOCK_LEN+1 edges; the first edge only moves IDLE to SYNC.
- `err_pulse` is never high for two cycles from a single mismatch. Back-to-back mismatches give back-to-back pulses.
- `rst_n` assertion mid-operation clears everything asynchronously. Deassertion is synchronous to `clk` via the upstream reset synchronizer.

## Structure
- Shared package/header `lab3_pkg`:
  - 2-bit state encodings `ST_IDLE=0`, `ST_SYNC=1`, `ST_LOCKED=2`, `ST_FAIL=3`.
  - Default `SEED`.
  - `err_cnt` width constant 5.
- One sub-module, `lab3_sat_cnt` (parameterised width, inc/clr, saturating), instantiated for `err_cnt` and `run`.
- Next-state logic and the `exp` register stay in the top module.

## Test plan
Parameters for all scenarios: DFF_num=8, SEED=8'h55, LOCK_LEN=4, ERR_LIMIT=3.

1. Aligned lock: reset, `en=1`, `d`=55, AA, 55, AA, … → `locked=1` after the 4th sampled edge in SYNC; `err_cnt=0`; `err_pulse` never high.
2. Phase slip: `d`=AA, 55, AA, 55 from SYNC entry → `run`=1, 2, 3, 4; `locked=1` on the 4th sample.
3. Garbage during sync: 55, AA, 0F, 55, AA, 55, AA → `run` resets at 0F; `locked` only after the last four samples.
4. Single error while locked: the correct sequence with one sample replaced by 00 → one-cycle `err_pulse`, `err_cnt=1`, `locked` stays 1, later samples match.
5. Fail and clear:
   - Three mismatches while locked → `fail=1`, `locked=0`, `err_cnt=3`.
   - Dropping `en` has no effect.
   - `clr` pulse → IDLE, `fail=0`, `err_cnt=0`.
6. Async reset mid-LOCKED: `rst_n` low between edges → `locked`, `fail`, `err_pulse` and `err_cnt` go to 0 immediately without a clock. After release, relock takes the full LOCK_LEN samples.
